// File: rtl/axi_stream_tile_source.sv
// Streams num_rows consecutive memory rows (wrapping addresses) as AXI-stream beats.
// A 2-entry head/tail queue absorbs the 1-cycle memory latency under backpressure.
module axi_stream_tile_source #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH-1:0]   num_rows,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [N*DATA_WIDTH-1:0] mem_rd_data,
  output logic [N*DATA_WIDTH-1:0] tdata,
  output logic                    tvalid,
  input  logic                    tready,
  output logic                    tlast
);
  localparam int W = N * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FINISH} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rows_q, rows_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  ret_q, ret_d;
  logic                  ret_last_q, ret_last_d;
  logic [W-1:0]          head_data_q, head_data_d;
  logic                  head_last_q, head_last_d;
  logic                  head_valid_q, head_valid_d;
  logic [W-1:0]          tail_data_q, tail_data_d;
  logic                  tail_last_q, tail_last_d;
  logic                  tail_valid_q, tail_valid_d;

  logic                  pop;
  logic                  rd_go;
  logic                  rd_is_last;
  logic [1:0]            level;

  assign pop        = head_valid_q & tready;
  assign rd_is_last = (rd_cnt_q == rows_q - ONE);
  // Rows held in the queue plus the row currently returning from memory.
  assign level      = {1'b0, head_valid_q} + {1'b0, tail_valid_q} + {1'b0, ret_q};
  // Counting this cycle's pop lets a read overlap the beat that frees its slot,
  // which is what sustains one beat per cycle without ever overfilling the queue.
  assign rd_go      = (state_q == S_READ) && ((level - {1'b0, pop}) < 2'd2);

  assign mem_rd_en   = rd_go;
  assign mem_rd_addr = rd_addr_q;
  assign tdata       = head_data_q;
  assign tvalid      = head_valid_q;
  assign tlast       = head_last_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH);

  always_comb begin
    state_d      = state_q;
    rows_d       = rows_q;
    rd_cnt_d     = rd_cnt_q;
    rd_addr_d    = rd_addr_q;
    ret_d        = rd_go;
    ret_last_d   = rd_go & rd_is_last;
    head_data_d  = head_data_q;
    head_last_d  = head_last_q;
    head_valid_d = head_valid_q;
    tail_data_d  = tail_data_q;
    tail_last_d  = tail_last_q;
    tail_valid_d = tail_valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d    = num_rows;
          rd_addr_d = base_addr;
          rd_cnt_d  = '0;
          state_d   = (num_rows == '0) ? S_FINISH : S_READ;
        end
      end
      S_READ: begin
        if (rd_go) begin
          rd_addr_d = rd_addr_q + ONE;
          rd_cnt_d  = rd_cnt_q + ONE;
          if (rd_is_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head_last_q) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Pop shifts the tail forward first, so a same-cycle push lands behind it.
    if (pop) begin
      head_data_d  = tail_data_q;
      head_last_d  = tail_last_q;
      head_valid_d = tail_valid_q;
      tail_valid_d = 1'b0;
    end
    if (ret_q) begin
      if (!head_valid_d) begin
        head_data_d  = mem_rd_data;
        head_last_d  = ret_last_q;
        head_valid_d = 1'b1;
      end else begin
        tail_data_d  = mem_rd_data;
        tail_last_d  = ret_last_q;
        tail_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rows_q       <= '0;
      rd_cnt_q     <= '0;
      rd_addr_q    <= '0;
      ret_q        <= 1'b0;
      ret_last_q   <= 1'b0;
      head_data_q  <= '0;
      head_last_q  <= 1'b0;
      head_valid_q <= 1'b0;
      tail_data_q  <= '0;
      tail_last_q  <= 1'b0;
      tail_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rows_q       <= rows_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_addr_q    <= rd_addr_d;
      ret_q        <= ret_d;
      ret_last_q   <= ret_last_d;
      head_data_q  <= head_data_d;
      head_last_q  <= head_last_d;
      head_valid_q <= head_valid_d;
      tail_data_q  <= tail_data_d;
      tail_last_q  <= tail_last_d;
      tail_valid_q <= tail_valid_d;
    end
  end
endmodule

// File: tb/tb_axi_stream_tile_source.sv
// Bench for axi_stream_tile_source: per-cycle transfer model plus literal checks.
module tb_axi_stream_tile_source;
  logic        clk = 1'b0;
  logic        reset, start, tready;
  logic [7:0]  base_addr, num_rows;
  logic        busy, done, mem_rd_en, tvalid, tlast;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_rd_data, tdata;

  always #5 clk = ~clk;

  axi_stream_tile_source #(.N(4), .DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast)
  );

  function automatic logic [31:0] row_val(input logic [7:0] a);
    return 32'hA0A0A0A0 + {24'h0, a};
  endfunction

  // Synchronous-read memory: row data valid the cycle after the read strobe.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= row_val(mem_rd_addr);

  int total = 0;
  int bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transfer model: what has been read and sent so far, relative to the accepted start.
  bit          m_active, m_full, m_stall;
  int          m_cyc, m_n, m_rd, m_beat, done_cyc;
  logic [7:0]  m_base;
  logic [31:0] m_prev;
  logic [7:0]  addr_log[$];
  logic [31:0] beat_log[$];
  bit          last_log[$];

  task automatic check_cycle();
    logic [7:0] a;
    if (reset) begin
      m_active = 0;
      return;
    end
    if (!m_active) begin
      cmp("idle_tvalid", tvalid, 0);
      cmp("idle_busy", busy, 0);
      cmp("idle_done", done, 0);
      cmp("idle_rd_en", mem_rd_en, 0);
      if (start) begin
        m_active = 1; m_base = base_addr; m_n = num_rows;
        m_cyc = 0; m_rd = 0; m_beat = 0; m_stall = 0;
      end
      return;
    end
    m_cyc++;
    cmp("busy", busy, 1);
    if (m_full) begin
      cmp("rd_en_timing", mem_rd_en, (m_cyc >= 1 && m_cyc <= m_n));
      cmp("tvalid_timing", tvalid, (m_cyc >= 3 && m_cyc <= m_n + 2));
      cmp("done_timing", done, (m_n == 0) ? (m_cyc == 1) : (m_cyc == m_n + 3));
    end
    if (mem_rd_en) begin
      a = m_base + m_rd[7:0];
      cmp("rd_addr", mem_rd_addr, a);
      cmp("rd_within_count", m_rd < m_n, 1);
      addr_log.push_back(mem_rd_addr);
      m_rd++;
    end
    if (m_stall) begin
      cmp("hold_tvalid", tvalid, 1);
      cmp("hold_tdata", tdata, m_prev);
    end
    if (tvalid) begin
      a = m_base + m_beat[7:0];
      cmp("tdata", tdata, row_val(a));
      cmp("tlast", tlast, m_beat == m_n - 1);
      m_prev  = tdata;
      m_stall = !tready;
      if (tready) begin
        beat_log.push_back(tdata);
        last_log.push_back(tlast);
        m_beat++;
      end
    end else begin
      m_stall = 0;
    end
    cmp("outstanding_le_2", (m_rd - m_beat) <= 2, 1);
    if (done) begin
      cmp("done_all_beats", m_beat, m_n);
      cmp("done_all_reads", m_rd, m_n);
      done_cyc = m_cyc;
      m_active = 0;
    end else if (m_cyc > 300) begin
      total++; bad++;
      $display("FAIL timeout: no done after %0d cycles, want done", m_cyc);
      m_active = 0;
    end
  endtask

  // mode 0: tready=1, 1: pattern 1,0,0, 2: random. poke: start pulse mid-transfer.
  // rst_beats>0: after that many beats hold tready=0, then reset.
  task automatic run(input logic [7:0] b, input int n, input int mode, input bit poke, input int rst_beats);
    bit launched = 0;
    int c = 0;
    int stall_cnt = 0;
    addr_log.delete(); beat_log.delete(); last_log.delete();
    done_cyc = -1;
    m_full = (mode == 0) && (rst_beats == 0);
    for (int g = 0; g < 400; g++) begin
      @(negedge clk);
      start = 0; reset = 0;
      if (!launched) begin
        start = 1; base_addr = b; num_rows = n[7:0]; launched = 1;
        tready = 1;
      end else if (!m_active) begin
        tready = 0;
        #1 check_cycle();
        break;
      end else begin
        case (mode)
          0:       tready = 1;
          1:       tready = (c % 3 == 0);
          default: tready = 1'($urandom_range(0, 1));
        endcase
        c++;
        if (poke && m_cyc == 2) begin
          start = 1; base_addr = b + 8'h40; num_rows = n[7:0] + 8'd3;
        end
        if (rst_beats > 0 && m_beat >= rst_beats) begin
          tready = 0;
          stall_cnt++;
          if (stall_cnt == 3) reset = 1;
        end
      end
      #1 check_cycle();
    end
  endtask

  initial begin
    reset = 1; start = 0; tready = 0; base_addr = 0; num_rows = 0;
    repeat (2) @(negedge clk);
    #1;
    cmp("rst_tvalid", tvalid, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_done", done, 0);
    cmp("rst_rd_en", mem_rd_en, 0);
    cmp("rst_rd_addr", mem_rd_addr, 0);
    cmp("rst_tdata", tdata, 0);
    cmp("rst_tlast", tlast, 0);
    m_active = 0;

    // Full rate, base 0, four rows
    run(8'h00, 4, 0, 0, 0);
    cmp("t1_done_cyc", done_cyc, 7);
    cmp("t1_beats", beat_log.size(), 4);
    cmp("t1_beat0", beat_log[0], 32'hA0A0A0A0);
    cmp("t1_beat3", beat_log[3], 32'hA0A0A0A3);
    cmp("t1_last2", last_log[2], 0);
    cmp("t1_last3", last_log[3], 1);

    // Backpressure 1,0,0
    run(8'h10, 6, 1, 0, 0);
    cmp("t2_beats", beat_log.size(), 6);
    cmp("t2_beat5", beat_log[5], 32'hA0A0A0B5);

    // Zero and single row
    run(8'h30, 0, 0, 0, 0);
    cmp("t3_zero_done_cyc", done_cyc, 1);
    cmp("t3_zero_reads", addr_log.size(), 0);
    run(8'h31, 1, 0, 0, 0);
    cmp("t3_one_beats", beat_log.size(), 1);
    cmp("t3_one_data", beat_log[0], 32'hA0A0A0D1);
    cmp("t3_one_last", last_log[0], 1);

    // Address wrap
    run(8'hFE, 4, 0, 0, 0);
    cmp("t4_addr0", addr_log[0], 8'hFE);
    cmp("t4_addr1", addr_log[1], 8'hFF);
    cmp("t4_addr2", addr_log[2], 8'h00);
    cmp("t4_addr3", addr_log[3], 8'h01);

    // Start while busy is ignored
    run(8'h20, 5, 0, 1, 0);
    cmp("t5_beats", beat_log.size(), 5);
    cmp("t5_done_cyc", done_cyc, 8);

    // Reset mid-transfer, then a fresh transfer
    run(8'h50, 5, 0, 0, 2);
    cmp("t6_done_never", done_cyc, -1);
    run(8'h60, 3, 0, 0, 0);
    cmp("t6_after_beat0", beat_log[0], 32'hA0A0A100);
    cmp("t6_after_done_cyc", done_cyc, 6);

    for (int i = 0; i < 30; i++)
      run(8'($urandom), $urandom_range(0, 9), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
